// File: rtl/fb_pkg.sv
// Shared definitions for the ping-pong frame buffer.
//   wr_state_e  : writer FSM encodings (W_IDLE, W_ACTIVE)
//   frame_pix() : pixels per frame from line length and line count
//   addr_width(): bits needed to address one bank of frame_pix() words
package fb_pkg;

  typedef enum logic {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wr_state_e;

  function automatic int frame_pix(input int h_res, input int v_res);
    return h_res * v_res;
  endfunction

  // A one-pixel frame still needs a 1-bit address so no vector collapses to zero width.
  function automatic int addr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dp_bram.sv
// Simple dual-port block RAM: one write port and one registered read port.
// Ports:
//   clk   : clock for both ports
//   we    : write enable, waddr/wdata : write address and data
//   re    : read enable,  raddr       : read address
//   rdata : read data, valid the cycle after re, held while re is low
// Contents are not reset so the array maps onto block RAM.
module dp_bram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Two-bank ping-pong frame buffer between a camera writer and a display reader.
// The camera fills wr_bank while the display scans rd_bank; a display frame
// start swaps the banks once a complete frame is waiting (unless frozen).
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   wr_sof/wr_valid/wr_data : camera frame start, pixel strobe, pixel
//   rd_sof/rd_en          : display frame start, pixel request
//   rd_data/rd_valid      : display pixel (1-cycle latency) and qualifier
//   freeze                : suppresses bank swaps while high
//   wr_bank/rd_bank       : current bank of each side
//   frame_ready           : a complete unconsumed frame sits in wr_bank
//   has_frame             : at least one complete frame was ever written
//   ovf                   : sticky, pixel arrived with no frame in progress
//   drop_cnt              : saturating count of abandoned/overwritten frames
module pingpong_frame_buffer
  import fb_pkg::*;
#(
  parameter int               PIX_W = 16,
  parameter int               H_RES = 320,
  parameter int               V_RES = 240,
  parameter logic [PIX_W-1:0] BLANK = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_sof,
  input  logic             wr_valid,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_sof,
  input  logic             rd_en,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             freeze,
  output logic             wr_bank,
  output logic             rd_bank,
  output logic             frame_ready,
  output logic             has_frame,
  output logic             ovf,
  output logic [7:0]       drop_cnt
);

  localparam int FRAME_PIX = frame_pix(H_RES, V_RES);
  localparam int AW        = addr_width(FRAME_PIX);
  localparam int PAW       = AW + 1;

  localparam logic [AW-1:0]  LAST_ADDR  = AW'(FRAME_PIX - 1);
  localparam logic [PAW-1:0] BANK1_BASE = PAW'(FRAME_PIX);

  wr_state_e      wr_state_q, wr_state_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic           frame_ready_q, frame_ready_d;
  logic           has_frame_q, has_frame_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;
  logic           rd_valid_q, rd_valid_d;
  logic           blank_sel_q, blank_sel_d;

  logic           swap;
  logic [AW-1:0]  wr_cur_addr;
  logic [AW-1:0]  rd_cur_addr;
  logic           mem_we;
  logic           mem_re;
  logic [PAW-1:0] mem_waddr;
  logic [PAW-1:0] mem_raddr;
  logic [PIX_W-1:0] mem_rdata;

  always_comb begin
    wr_state_d    = wr_state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    frame_ready_d = frame_ready_q;
    has_frame_d   = has_frame_q;
    ovf_d         = ovf_q;
    drop_cnt_d    = drop_cnt_q;
    blank_sel_d   = blank_sel_q;
    rd_valid_d    = rd_en;

    swap = rd_sof && frame_ready_q && !freeze;

    // The two banks always stay complementary, so reader and writer never collide.
    if (swap) begin
      wr_bank_d     = ~wr_bank_q;
      rd_bank_d     = wr_bank_q;
      frame_ready_d = 1'b0;
    end

    // A frame start restarts the writer; it counts as a drop unless a swap
    // in the same cycle already moved the pending frame to the reader.
    if (wr_sof) begin
      wr_state_d = W_ACTIVE;
      wr_addr_d  = '0;
      if (!swap && (wr_state_q == W_ACTIVE || frame_ready_q)) begin
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        frame_ready_d = 1'b0;
      end
    end

    wr_cur_addr = wr_sof ? '0 : wr_addr_q;
    mem_we      = wr_valid && (wr_sof || wr_state_q == W_ACTIVE);

    if (wr_valid && !mem_we) ovf_d = 1'b1;

    if (mem_we) begin
      if (wr_cur_addr == LAST_ADDR) begin
        frame_ready_d = 1'b1;
        has_frame_d   = 1'b1;
        wr_state_d    = W_IDLE;
        wr_addr_d     = '0;
      end else begin
        wr_addr_d = wr_cur_addr + AW'(1);
      end
    end

    // Writes use the post-swap bank so a coincident new frame lands correctly.
    mem_waddr = wr_bank_d ? BANK1_BASE + PAW'(wr_cur_addr) : PAW'(wr_cur_addr);

    rd_cur_addr = rd_sof ? '0 : rd_addr_q;
    mem_re      = rd_en;
    if (rd_sof) rd_addr_d = '0;
    if (rd_en) begin
      rd_addr_d   = (rd_cur_addr == LAST_ADDR) ? '0 : rd_cur_addr + AW'(1);
      blank_sel_d = !has_frame_q;
    end

    mem_raddr = rd_bank_d ? BANK1_BASE + PAW'(rd_cur_addr) : PAW'(rd_cur_addr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_q    <= W_IDLE;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      frame_ready_q <= 1'b0;
      has_frame_q   <= 1'b0;
      ovf_q         <= 1'b0;
      drop_cnt_q    <= '0;
      rd_valid_q    <= 1'b0;
      blank_sel_q   <= 1'b1;
    end else begin
      wr_state_q    <= wr_state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      frame_ready_q <= frame_ready_d;
      has_frame_q   <= has_frame_d;
      ovf_q         <= ovf_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_valid_q    <= rd_valid_d;
      blank_sel_q   <= blank_sel_d;
    end
  end

  dp_bram #(
    .DEPTH (2 * FRAME_PIX),
    .WIDTH (PIX_W),
    .AW    (PAW)
  ) u_bram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (wr_data),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // The RAM output register is not reset, so a registered select forces BLANK
  // after reset and for reads taken before any frame existed.
  assign rd_data     = blank_sel_q ? BLANK : mem_rdata;
  assign rd_valid    = rd_valid_q;
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign frame_ready = frame_ready_q;
  assign has_frame   = has_frame_q;
  assign ovf         = ovf_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed testbench for pingpong_frame_buffer with a 4x2 (8 pixel) frame.
module tb_pingpong_frame_buffer;

  localparam int               PIX_W = 16;
  localparam logic [PIX_W-1:0] BLANK = 16'h0BAD;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_sof, wr_valid, rd_sof, rd_en, freeze;
  logic [PIX_W-1:0] wr_data;
  logic [PIX_W-1:0] rd_data;
  logic             rd_valid, wr_bank, rd_bank, frame_ready, has_frame, ovf;
  logic [7:0]       drop_cnt;

  int check_cnt = 0;
  int pass_cnt  = 0;

  pingpong_frame_buffer #(
    .PIX_W (PIX_W),
    .H_RES (4),
    .V_RES (2),
    .BLANK (BLANK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_sof      (wr_sof),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .rd_sof      (rd_sof),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .freeze      (freeze),
    .wr_bank     (wr_bank),
    .rd_bank     (rd_bank),
    .frame_ready (frame_ready),
    .has_frame   (has_frame),
    .ovf         (ovf),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_sof = 0; wr_valid = 0; wr_data = '0; rd_sof = 0; rd_en = 0;
  endtask

  task automatic send_sof();
    idle_inputs();
    wr_sof = 1;
    step();
    wr_sof = 0;
  endtask

  task automatic send_pixels(input logic [PIX_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1;
      wr_data  = base + PIX_W'(i);
      step();
    end
    wr_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    freeze = 0;
    rst_n  = 0;
    step();
    step();
    rst_n = 1;
    check_cnt++;
    if ({wr_bank, rd_bank, frame_ready, has_frame, ovf, rd_valid} !== 6'b010000)
      $display("[TB] FAIL reset_flags: got %b expected 010000",
               {wr_bank, rd_bank, frame_ready, has_frame, ovf, rd_valid});
    else pass_cnt++;
    check_cnt++;
    if (drop_cnt !== 8'd0) $display("[TB] FAIL reset_drop: got %0d expected 0", drop_cnt);
    else pass_cnt++;
    check_cnt++;
    if (rd_data !== BLANK) $display("[TB] FAIL reset_rd_data: got %h expected %h", rd_data, BLANK);
    else pass_cnt++;
  endtask

  task automatic test_blank_read();
    idle_inputs();
    rd_sof = 1;
    step();
    rd_sof = 0;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1;
      step();
      check_cnt++;
      if (rd_valid !== 1'b1 || rd_data !== BLANK || has_frame !== 1'b0)
        $display("[TB] FAIL blank_beat%0d: got valid=%b data=%h has_frame=%b expected 1 %h 0",
                 i, rd_valid, rd_data, has_frame, BLANK);
      else pass_cnt++;
    end
    rd_en = 0;
    step();
    check_cnt++;
    if (rd_valid !== 1'b0) $display("[TB] FAIL blank_valid_drop: got %b expected 0", rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    send_sof();
    send_pixels(16'h0001, 7);
    check_cnt++;
    if (frame_ready !== 1'b0) $display("[TB] FAIL ready_early: got %b expected 0", frame_ready);
    else pass_cnt++;
    send_pixels(16'h0008, 1);
    check_cnt++;
    if (frame_ready !== 1'b1 || has_frame !== 1'b1)
      $display("[TB] FAIL ready_set: got %b%b expected 11", frame_ready, has_frame);
    else pass_cnt++;
    rd_sof = 1;
    step();
    rd_sof = 0;
    check_cnt++;
    if ({rd_bank, wr_bank, frame_ready} !== 3'b010)
      $display("[TB] FAIL first_swap: got %b expected 010", {rd_bank, wr_bank, frame_ready});
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1;
      step();
      check_cnt++;
      if (rd_valid !== 1'b1 || rd_data !== PIX_W'(i + 1))
        $display("[TB] FAIL frame1_pix%0d: got %b/%h expected 1/%h", i, rd_valid, rd_data, PIX_W'(i + 1));
      else pass_cnt++;
    end
    rd_en = 0;
    step();
    check_cnt++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0008)
      $display("[TB] FAIL rd_hold: got %b/%h expected 0/0008", rd_valid, rd_data);
    else pass_cnt++;
  endtask

  task automatic test_ovf();
    send_sof();
    send_pixels(16'h0011, 8);
    send_pixels(16'h00FF, 1);
    check_cnt++;
    if (ovf !== 1'b1) $display("[TB] FAIL ovf_set: got %b expected 1", ovf);
    else pass_cnt++;
    rd_sof = 1;
    step();
    rd_sof = 0;
    check_cnt++;
    if (rd_bank !== 1'b1 || wr_bank !== 1'b0)
      $display("[TB] FAIL second_swap: got rd=%b wr=%b expected rd=1 wr=0", rd_bank, wr_bank);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1;
      step();
      check_cnt++;
      if (rd_data !== 16'h0011 + PIX_W'(i))
        $display("[TB] FAIL ovf_mem_pix%0d: got %h expected %h", i, rd_data, 16'h0011 + PIX_W'(i));
      else pass_cnt++;
    end
    rd_en = 0;
  endtask

  task automatic test_drop();
    send_sof();
    send_pixels(16'h0021, 8);
    send_sof();
    send_pixels(16'h0031, 3);
    check_cnt++;
    if (drop_cnt !== 8'd1 || frame_ready !== 1'b0 || ovf !== 1'b1)
      $display("[TB] FAIL drop_overwrite: got cnt=%0d ready=%b ovf=%b expected 1 0 1", drop_cnt, frame_ready, ovf);
    else pass_cnt++;
    send_sof();
    send_pixels(16'h0041, 8);
    check_cnt++;
    if (drop_cnt !== 8'd2 || frame_ready !== 1'b1)
      $display("[TB] FAIL drop_short: got cnt=%0d ready=%b expected 2 1", drop_cnt, frame_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    rd_sof = 1; wr_sof = 1; wr_valid = 1; wr_data = 16'h0051;
    step();
    idle_inputs();
    check_cnt++;
    if ({rd_bank, wr_bank, frame_ready} !== 3'b010 || drop_cnt !== 8'd2)
      $display("[TB] FAIL coincident_swap: got %b cnt=%0d expected 010 cnt=2", {rd_bank, wr_bank, frame_ready}, drop_cnt);
    else pass_cnt++;
    send_pixels(16'h0052, 7);
    check_cnt++;
    if (frame_ready !== 1'b1) $display("[TB] FAIL coincident_ready: got %b expected 1", frame_ready);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1;
      step();
      check_cnt++;
      if (rd_data !== 16'h0041 + PIX_W'(i))
        $display("[TB] FAIL old_bank_pix%0d: got %h expected %h", i, rd_data, 16'h0041 + PIX_W'(i));
      else pass_cnt++;
    end
    rd_en = 0;
    rd_sof = 1;
    step();
    rd_sof = 0;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1;
      step();
      check_cnt++;
      if (rd_data !== 16'h0051 + PIX_W'(i))
        $display("[TB] FAIL new_bank_pix%0d: got %h expected %h", i, rd_data, 16'h0051 + PIX_W'(i));
      else pass_cnt++;
    end
    rd_en = 0;
  endtask

  task automatic test_freeze();
    send_sof();
    send_pixels(16'h0061, 8);
    freeze = 1;
    rd_sof = 1;
    step();
    rd_sof = 0;
    check_cnt++;
    if ({rd_bank, wr_bank, frame_ready} !== 3'b101)
      $display("[TB] FAIL freeze_no_swap: got %b expected 101", {rd_bank, wr_bank, frame_ready});
    else pass_cnt++;
    for (int i = 0; i < 9; i++) begin
      rd_en = 1;
      step();
      check_cnt++;
      if (rd_data !== 16'h0051 + PIX_W'(i % 8))
        $display("[TB] FAIL freeze_pix%0d: got %h expected %h", i, rd_data, 16'h0051 + PIX_W'(i % 8));
      else pass_cnt++;
    end
    rd_en  = 0;
    freeze = 0;
  endtask

  task automatic test_drop_saturate();
    send_sof();
    for (int i = 0; i < 300; i++) begin
      wr_sof = 1;
      step();
    end
    wr_sof = 0;
    check_cnt++;
    if (drop_cnt !== 8'd255) $display("[TB] FAIL drop_saturate: got %0d expected 255", drop_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    send_sof();
    send_pixels(16'h0071, 4);
    rst_n = 0;
    rd_en = 1;
    step();
    check_cnt++;
    if ({wr_bank, rd_bank, frame_ready, has_frame, ovf, rd_valid} !== 6'b010000)
      $display("[TB] FAIL midreset_flags: got %b expected 010000",
               {wr_bank, rd_bank, frame_ready, has_frame, ovf, rd_valid});
    else pass_cnt++;
    check_cnt++;
    if (drop_cnt !== 8'd0 || rd_data !== BLANK)
      $display("[TB] FAIL midreset_data: got cnt=%0d data=%h expected 0 %h", drop_cnt, rd_data, BLANK);
    else pass_cnt++;
    rd_en = 0;
    rst_n = 1;
    rd_sof = 1; rd_en = 1;
    step();
    idle_inputs();
    check_cnt++;
    if (rd_valid !== 1'b1 || rd_data !== BLANK || rd_bank !== 1'b1)
      $display("[TB] FAIL midreset_read: got %b/%h bank=%b expected 1/%h bank=1", rd_valid, rd_data, rd_bank, BLANK);
    else pass_cnt++;
  endtask

  initial begin
    idle_inputs();
    freeze = 0;
    rst_n  = 0;
    test_reset();
    test_blank_read();
    test_write_read();
    test_ovf();
    test_drop();
    test_back_to_back();
    test_freeze();
    test_drop_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
